// File: rtl/instruction_prefetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetcher_pkg
// Brief    : Shared types, reset vectors and the real-mode address helper.
// Revision : 1.0 - initial release
// ============================================================================
package instruction_prefetcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PUSH_LO = 2'd2,
        ST_PUSH_HI = 2'd3
    } pf_state_e;

    localparam logic [15:0] C_RESET_CS = 16'hFFFF;
    localparam logic [15:0] C_RESET_IP = 16'h0000;

    // Real-mode physical address; the 21st bit is dropped (1 MiB wrap).
    function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] ofs);
        return {seg, 4'h0} + {4'h0, ofs};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_prefetcher.sv
`default_nettype none
// ============================================================================
// Module   : instruction_prefetcher
// Brief    : Fetches 16-bit words at CS:IP and pushes bytes into the
//            instruction FIFO; handles odd IP, IP wrap and redirects.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_prefetcher
    import instruction_prefetcher_pkg::*;
#(
    parameter logic [15:0] RESET_CS = C_RESET_CS,
    parameter logic [15:0] RESET_IP = C_RESET_IP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    input  logic        fifo_full,
    output logic        fifo_reset,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    input  logic [15:0] mem_data,
    output logic [15:0] fetch_ip
);

    pf_state_e   state_q, state_d;
    logic [15:0] fetch_ip_q, fetch_ip_d;
    logic [15:0] cs_q, cs_d;
    logic [15:0] req_ip_q, req_ip_d;
    logic [15:0] hold_q, hold_d;
    logic        discard_q, discard_d;
    logic        mem_access_q, mem_access_d;
    logic        fifo_reset_q, fifo_reset_d;
    logic [19:0] w_req_phys;

    // The request address is derived from the latched CS:IP, so it cannot
    // move while a transaction is outstanding even if fetch_ip is redirected.
    assign w_req_phys  = phys_addr(cs_q, req_ip_q);
    assign mem_address = w_req_phys[19:1];
    assign mem_access  = mem_access_q;
    assign fifo_reset  = fifo_reset_q;
    assign fetch_ip    = fetch_ip_q;

    always_comb begin
        state_d      = state_q;
        fetch_ip_d   = fetch_ip_q;
        cs_d         = cs_q;
        req_ip_d     = req_ip_q;
        hold_d       = hold_q;
        discard_d    = discard_q;
        mem_access_d = mem_access_q;
        fifo_reset_d = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 8'h00;

        if (load_new_ip) begin
            fetch_ip_d   = new_ip;
            fifo_reset_d = 1'b1;
            hold_d       = 16'h0000;
            if (state_q == ST_FETCH) begin
                if (mem_ack) begin
                    mem_access_d = 1'b0;
                    discard_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    discard_d    = 1'b1;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_full) begin
                        cs_d         = cs;
                        req_ip_d     = fetch_ip_q;
                        mem_access_d = 1'b1;
                        state_d      = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        mem_access_d = 1'b0;
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            hold_d  = mem_data;
                            // An odd request address means only the high byte is wanted.
                            state_d = w_req_phys[0] ? ST_PUSH_HI : ST_PUSH_LO;
                        end
                    end
                end
                ST_PUSH_LO: begin
                    if (!fifo_full && !reset) begin
                        fifo_wr_en   = 1'b1;
                        fifo_wr_data = hold_q[7:0];
                        fetch_ip_d   = fetch_ip_q + 16'd1;
                        state_d      = ST_PUSH_HI;
                    end
                end
                ST_PUSH_HI: begin
                    if (!fifo_full && !reset) begin
                        fifo_wr_en   = 1'b1;
                        fifo_wr_data = hold_q[15:8];
                        fetch_ip_d   = fetch_ip_q + 16'd1;
                        state_d      = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fetch_ip_q   <= RESET_IP;
            cs_q         <= RESET_CS;
            req_ip_q     <= RESET_IP;
            hold_q       <= 16'h0000;
            discard_q    <= 1'b0;
            mem_access_q <= 1'b0;
            fifo_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_ip_q   <= fetch_ip_d;
            cs_q         <= cs_d;
            req_ip_q     <= req_ip_d;
            hold_q       <= hold_d;
            discard_q    <= discard_d;
            mem_access_q <= mem_access_d;
            fifo_reset_q <= fifo_reset_d;
        end
    end

endmodule
`default_nettype wire
